// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile: SCCB responder with a 256 x 8 register file.
// Decodes 3-phase writes and 2-phase reads addressed to DEV_ID. It exposes a
// write-event strobe and an asynchronous fabric read port.
// Optional feature macro: SCCB_SLAVE_ACK_EN. When defined, the slave pulls sda
// low through the 9th bit of ID/sub/write bytes. When undefined, that bit is
// left released.
module sccb_slave_regfile #(
  parameter logic [6:0]  DEV_ID   = 7'h21,
  parameter int unsigned SYS_FREQ = 100_000_000,
  parameter int unsigned BIT_RATE = 100_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] reg_raddr,
  output logic [7:0] reg_rdata
);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  if (SYS_FREQ / BIT_RATE < 40) begin : g_rate_check
    $error("sccb_slave_regfile: SYS_FREQ/BIT_RATE must be at least 40");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ID_BYTE, S_ID_ACK, S_SUB_BYTE, S_SUB_ACK,
    S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_NA, S_IGNORE
  } state_t;

  state_t     state, state_next;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [2:0] cnt;
  logic [7:0] shift, rx_byte, ptr, ptr_inc;
  logic       rd_flag, sda_drive;
  logic [7:0] regs [256];

  assign sda = sda_drive ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Bus event decode and byte assembly helpers.
  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    rx_byte   = {shift[6:0], sda_s2};
    byte_done = scl_rise & (cnt == 3'd7);
    ptr_inc   = ptr + 8'd1;
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Each ACK/NA state is left on the 9th rising edge, so
  // the falling edge that ends the 9th bit already sees the following byte
  // state and can set up its first drive value.
  always_comb begin
    state_next = state;
    if (stop_det) begin
      state_next = S_IDLE;
    end else if (start_det) begin
      state_next = S_ID_BYTE;
    end else if (scl_rise) begin
      case (state)
        S_ID_BYTE:  if (byte_done) state_next = (rx_byte[7:1] == DEV_ID) ? S_ID_ACK : S_IGNORE;
        S_ID_ACK:   state_next = rd_flag ? S_RD_BYTE : S_SUB_BYTE;
        S_SUB_BYTE: if (byte_done) state_next = S_SUB_ACK;
        S_SUB_ACK:  state_next = S_WR_BYTE;
        S_WR_BYTE:  if (byte_done) state_next = S_WR_ACK;
        S_WR_ACK:   state_next = S_WR_BYTE;
        S_RD_BYTE:  if (byte_done) state_next = S_RD_NA;
        S_RD_NA:    state_next = sda_s2 ? S_IGNORE : S_RD_BYTE;
        default:    state_next = state;
      endcase
    end
  end

  // Outputs derived directly from state and the register file.
  always_comb begin
    busy      = (state != S_IDLE);
    reg_rdata = regs[reg_raddr];
  end

  // Datapath: bit counter, shifter, pointer, register file and sda drive.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt       <= '0;
      shift     <= '0;
      ptr       <= '0;
      rd_flag   <= 1'b0;
      sda_drive <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int unsigned i = 0; i < 256; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det || stop_det) begin
        cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          S_ID_BYTE, S_SUB_BYTE, S_WR_BYTE: begin
            shift <= rx_byte;
            cnt   <= cnt + 3'd1;
          end
          S_RD_BYTE: cnt <= cnt + 3'd1;
          default: ;
        endcase
        if (state == S_ID_BYTE && byte_done) rd_flag <= sda_s2;
        if (state == S_SUB_BYTE && byte_done) ptr <= rx_byte;
        if (state == S_WR_BYTE && byte_done) begin
          regs[ptr] <= rx_byte;
          wr_addr   <= ptr;
          wr_data   <= rx_byte;
          wr_valid  <= 1'b1;
        end
        if (state == S_WR_ACK) ptr <= ptr_inc;
        if (state == S_ID_ACK && rd_flag) shift <= regs[ptr];
        if (state == S_RD_NA && !sda_s2) begin
          ptr   <= ptr_inc;
          shift <= regs[ptr_inc];
        end
      end else if (scl_fall) begin
        case (state)
          S_ID_ACK, S_SUB_ACK, S_WR_ACK: sda_drive <= ACK_DRIVE;
          S_RD_BYTE: begin
            sda_drive <= ~shift[7];
            shift     <= {shift[6:0], 1'b0};
          end
          default: sda_drive <= 1'b0;
        endcase
      end
    end
  end

endmodule
